csr_commit_ctrl: RTL and testbench

Commit-side controller for CSR instructions. It receives the scoreboard head when that entry is a CSR op, and takes the buffered CSR address and write operand from the issue-side CSR buffer. It runs the access against the CSR register file with a req/gnt/rvalid handshake, then retires the instruction. On retirement it pulses the buffer's commit strobe, writes back the read value or raises the CSR exception, and requests a pipeline flush when the CSR file reports a side-effecting write.

---
 rtl/csr_commit_ctrl_pkg.sv | 48 ++++
 rtl/csr_commit_ctrl_if.sv | 50 +++++
 rtl/csr_commit_ctrl.sv | 94 +++++++++
 tb/tb_csr_commit_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_commit_ctrl_pkg.sv
// Shared types for the commit-side CSR controller: command encoding, FSM states,
// latched access/response records and the response capture helper.
package csr_commit_ctrl_pkg;

  localparam int XLEN   = 64;
  localparam int VLEN   = 64;
  localparam int CSR_AW = 12;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FLUSH = 3'd4
  } commit_state_t;

  typedef struct packed {
    csr_cmd_t              cmd;
    logic [CSR_AW-1:0]     addr;
    logic [XLEN-1:0]       wdata;
    logic [VLEN-1:0]       pc;
  } csr_access_t;

  typedef struct packed {
    logic [XLEN-1:0]       rdata;
    logic                  ex;
    logic                  side_effect;
  } csr_resp_t;

  // A faulting access never requests a flush, so the side-effect bit is masked at capture.
  function automatic csr_resp_t make_resp(input logic [XLEN-1:0] rdata,
                                          input logic            ex,
                                          input logic            side_effect);
    csr_resp_t r;
    r.rdata       = rdata;
    r.ex          = ex;
    r.side_effect = side_effect && !ex;
    return r;
  endfunction

endpackage

// File: rtl/csr_commit_ctrl_if.sv
// Signal bundle between the CSR commit controller, the scoreboard head / CSR buffer
// and the CSR register file. master = the controller, slave = its environment.
interface csr_commit_ctrl_if;
  import csr_commit_ctrl_pkg::*;

  logic                  flush_i;
  logic                  halt_i;
  logic                  commit_valid_i;
  csr_cmd_t              commit_cmd_i;
  logic [VLEN-1:0]       commit_pc_i;
  logic [CSR_AW-1:0]     buf_addr_i;
  logic [XLEN-1:0]       buf_wdata_i;

  logic                  csr_req_o;
  csr_cmd_t              csr_cmd_o;
  logic [CSR_AW-1:0]     csr_addr_o;
  logic [XLEN-1:0]       csr_wdata_o;
  logic                  csr_gnt_i;
  logic                  csr_rvalid_i;
  logic [XLEN-1:0]       csr_rdata_i;
  logic                  csr_ex_i;
  logic                  csr_side_effect_i;

  logic                  buf_commit_o;
  logic                  commit_ack_o;
  logic                  wb_valid_o;
  logic [XLEN-1:0]       wb_data_o;
  logic                  ex_valid_o;
  logic [VLEN-1:0]       ex_pc_o;
  logic                  flush_pipeline_o;

  modport master (
    input  flush_i, halt_i, commit_valid_i, commit_cmd_i, commit_pc_i,
           buf_addr_i, buf_wdata_i,
           csr_gnt_i, csr_rvalid_i, csr_rdata_i, csr_ex_i, csr_side_effect_i,
    output csr_req_o, csr_cmd_o, csr_addr_o, csr_wdata_o,
           buf_commit_o, commit_ack_o, wb_valid_o, wb_data_o,
           ex_valid_o, ex_pc_o, flush_pipeline_o
  );

  modport slave (
    output flush_i, halt_i, commit_valid_i, commit_cmd_i, commit_pc_i,
           buf_addr_i, buf_wdata_i,
           csr_gnt_i, csr_rvalid_i, csr_rdata_i, csr_ex_i, csr_side_effect_i,
    input  csr_req_o, csr_cmd_o, csr_addr_o, csr_wdata_o,
           buf_commit_o, commit_ack_o, wb_valid_o, wb_data_o,
           ex_valid_o, ex_pc_o, flush_pipeline_o
  );

endinterface

// File: rtl/csr_commit_ctrl.sv
// Commit-side CSR controller: latches the head CSR op, runs one req/gnt/rvalid access
// against the CSR file, then retires it with writeback, exception or pipeline flush.
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  csr_commit_ctrl_if.master bus
);

  commit_state_t state_reg, state_next;
  csr_access_t   acc_reg, acc_next;
  csr_resp_t     resp_reg, resp_next;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    resp_next  = resp_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.commit_valid_i && !bus.halt_i && !bus.flush_i) begin
          acc_next.cmd   = bus.commit_cmd_i;
          acc_next.addr  = bus.buf_addr_i;
          acc_next.wdata = bus.buf_wdata_i;
          acc_next.pc    = bus.commit_pc_i;
          state_next     = S_REQ;
        end
      end
      S_REQ: begin
        // Before the grant nothing has reached the CSR file, so a flush can still abort.
        if (bus.flush_i) begin
          state_next = S_IDLE;
        end else if (bus.csr_gnt_i) begin
          if (bus.csr_rvalid_i) begin
            resp_next  = make_resp(bus.csr_rdata_i, bus.csr_ex_i, bus.csr_side_effect_i);
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.csr_rvalid_i) begin
          resp_next  = make_resp(bus.csr_rdata_i, bus.csr_ex_i, bus.csr_side_effect_i);
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = resp_reg.side_effect ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      resp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      resp_reg  <= resp_next;
    end
  end

  // Every output is a decode of registered state, never of a live input.
  logic in_done;
  logic retire_ok;
  logic retire_ex;

  assign in_done   = (state_reg == S_DONE);
  assign retire_ok = in_done && !resp_reg.ex;
  assign retire_ex = in_done &&  resp_reg.ex;

  assign bus.csr_req_o        = (state_reg == S_REQ);
  assign bus.csr_cmd_o        = acc_reg.cmd;
  assign bus.csr_addr_o       = acc_reg.addr;
  assign bus.csr_wdata_o      = acc_reg.wdata;

  assign bus.commit_ack_o     = in_done;
  assign bus.buf_commit_o     = retire_ok;
  assign bus.wb_valid_o       = retire_ok;
  assign bus.wb_data_o        = retire_ok ? resp_reg.rdata : '0;
  assign bus.ex_valid_o       = retire_ex;
  assign bus.ex_pc_o          = retire_ex ? acc_reg.pc : '0;
  assign bus.flush_pipeline_o = (state_reg == S_FLUSH);

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: directed scenarios plus randomized transactions checked
// cycle by cycle against an outcome-level model of each CSR commit.
module tb_csr_commit_ctrl;
  import csr_commit_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  csr_commit_ctrl_if bus();

  csr_commit_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] pc;
    int          g;
    int          r;
    logic [63:0] rdata;
    bit          ex;
    bit          se;
    bit          fl_wait;
  } txn_t;

  // {req, ack, wb_valid, wb_data, ex_valid, ex_pc, buf_commit, flush_pipeline}
  function automatic logic [133:0] obs();
    return {bus.csr_req_o, bus.commit_ack_o, bus.wb_valid_o, bus.wb_data_o,
            bus.ex_valid_o, bus.ex_pc_o, bus.buf_commit_o, bus.flush_pipeline_o};
  endfunction

  function automatic logic [133:0] pk(bit req, bit ack, bit wbv, logic [63:0] wbd,
                                      bit exv, logic [63:0] expc, bit bc, bit fl);
    return {req, ack, wbv, wbd, exv, expc, bc, fl};
  endfunction

  function automatic logic [77:0] fields();
    return {bus.csr_cmd_o, bus.csr_addr_o, bus.csr_wdata_o};
  endfunction

  function automatic txn_t mk(logic [1:0] cmd, logic [11:0] addr, logic [63:0] wdata,
                              logic [63:0] pc, int g, int r, logic [63:0] rdata,
                              bit ex, bit se, bit flw);
    txn_t t;
    t.cmd = cmd; t.addr = addr; t.wdata = wdata; t.pc = pc; t.g = g; t.r = r;
    t.rdata = rdata; t.ex = ex; t.se = se; t.fl_wait = flw;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(2'($urandom), 12'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom},
              ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
  endfunction

  task automatic arm(input txn_t t);
    bus.commit_valid_i = 1'b1;
    bus.commit_cmd_i   = csr_cmd_t'(t.cmd);
    bus.buf_addr_i     = t.addr;
    bus.buf_wdata_i    = t.wdata;
    bus.commit_pc_i    = t.pc;
  endtask

  task automatic scramble_buf();
    bus.commit_cmd_i = csr_cmd_t'(2'($urandom));
    bus.buf_addr_i   = 12'($urandom);
    bus.buf_wdata_i  = {$urandom, $urandom};
    bus.commit_pc_i  = {$urandom, $urandom};
  endtask

  task automatic drive_resp(input txn_t t);
    bus.csr_rvalid_i      = 1'b1;
    bus.csr_rdata_i       = t.rdata;
    bus.csr_ex_i          = t.ex;
    bus.csr_side_effect_i = t.se;
  endtask

  // Caller has armed t at the current negedge with the DUT about to sample it in IDLE.
  task automatic do_txn(input txn_t t, input bit chain, input txn_t nx, input string tag);
    logic [133:0] e_idle;
    logic [133:0] e_req;
    logic [133:0] e_done;
    bit           exp_fl;
    e_idle = pk(0, 0, 0, '0, 0, '0, 0, 0);
    e_req  = pk(1, 0, 0, '0, 0, '0, 0, 0);
    e_done = pk(0, 1, !t.ex, t.ex ? 64'd0 : t.rdata, t.ex, t.ex ? t.pc : 64'd0, !t.ex, 0);
    exp_fl = !t.ex && t.se;

    @(negedge clk);
    bus.commit_valid_i = 1'b0;
    scramble_buf();
    n_cmp++;
    if (obs() !== e_req) begin
      n_fail++; $display("FAIL %s req_enter: got %h exp %h", tag, obs(), e_req);
    end
    n_cmp++;
    if (fields() !== {t.cmd, t.addr, t.wdata}) begin
      n_fail++; $display("FAIL %s req_fields: got %h exp %h", tag, fields(), {t.cmd, t.addr, t.wdata});
    end
    for (int i = 0; i < t.g; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== e_req) begin
        n_fail++; $display("FAIL %s req_hold%0d: got %h exp %h", tag, i, obs(), e_req);
      end
    end

    bus.csr_gnt_i = 1'b1;
    if (t.r == 0) drive_resp(t);
    @(negedge clk);
    bus.csr_gnt_i    = 1'b0;
    bus.csr_rvalid_i = 1'b0;
    if (t.r > 0) begin
      n_cmp++;
      if (obs() !== e_idle) begin
        n_fail++; $display("FAIL %s wait0: got %h exp %h", tag, obs(), e_idle);
      end
      for (int i = 1; i < t.r; i++) begin
        bus.flush_i           = t.fl_wait;
        bus.halt_i            = 1'($urandom);
        bus.csr_gnt_i         = 1'($urandom);
        bus.csr_rdata_i       = {$urandom, $urandom};
        bus.csr_ex_i          = 1'($urandom);
        bus.csr_side_effect_i = 1'($urandom);
        @(negedge clk);
        bus.csr_gnt_i = 1'b0;
        n_cmp++;
        if (obs() !== e_idle) begin
          n_fail++; $display("FAIL %s wait%0d: got %h exp %h", tag, i, obs(), e_idle);
        end
      end
      bus.flush_i = t.fl_wait;
      drive_resp(t);
      @(negedge clk);
      bus.csr_rvalid_i = 1'b0;
    end
    bus.flush_i = 1'b0;
    bus.halt_i  = 1'b0;

    n_cmp++;
    if (obs() !== e_done) begin
      n_fail++; $display("FAIL %s done: got %h exp %h", tag, obs(), e_done);
    end
    if (chain) arm(nx);
    @(negedge clk);
    if (exp_fl) begin
      n_cmp++;
      if (obs() !== pk(0, 0, 0, '0, 0, '0, 0, 1)) begin
        n_fail++; $display("FAIL %s flush: got %h exp %h", tag, obs(), pk(0, 0, 0, '0, 0, '0, 0, 1));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== e_idle) begin
      n_fail++; $display("FAIL %s idle_after: got %h exp %h", tag, obs(), e_idle);
    end
    $display("txn %s cmd=%0d addr=%h g=%0d r=%0d ex=%0b se=%0b chain=%0b",
             tag, t.cmd, t.addr, t.g, t.r, t.ex, t.se, chain);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.commit_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h exp 0", obs());
    end
    n_cmp++;
    if (fields() !== '0) begin
      n_fail++; $display("FAIL reset_fields: got %h exp 0", fields());
    end
    bus.commit_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_release: got %h exp 0", obs());
    end
  endtask

  task automatic test_read_success();
    txn_t t;
    t = mk(2'd0, 12'h300, 64'h0, 64'h8000_0000, 0, 1, 64'h1800, 0, 0, 0);
    arm(t);
    do_txn(t, 0, t, "read");
  endtask

  task automatic test_exception();
    txn_t t;
    t = mk(2'd1, 12'h7c0, 64'h55, 64'h8000_0040, 0, 1, 64'hdead, 1, 1, 0);
    arm(t);
    do_txn(t, 0, t, "exception");
  endtask

  task automatic test_side_effect();
    txn_t t;
    t = mk(2'd1, 12'h180, 64'h8000_0000_0008_0000, 64'h8000_0100, 1, 0, 64'h0, 0, 1, 0);
    arm(t);
    do_txn(t, 0, t, "side_effect");
  endtask

  task automatic test_flush_in_req(input bit with_gnt);
    txn_t t;
    t = mk(2'd2, 12'h341, 64'h4, 64'h8000_0200, 3, 0, 64'h0, 0, 0, 0);
    arm(t);
    @(negedge clk);
    bus.commit_valid_i = 1'b0;
    n_cmp++;
    if (obs() !== pk(1, 0, 0, '0, 0, '0, 0, 0)) begin
      n_fail++; $display("FAIL flush_req_enter: got %h exp req only", obs());
    end
    @(negedge clk);
    n_cmp++;
    if (bus.csr_req_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_req_hold: got %b exp 1", bus.csr_req_o);
    end
    bus.flush_i   = 1'b1;
    bus.csr_gnt_i = with_gnt;
    @(negedge clk);
    bus.flush_i   = 1'b0;
    bus.csr_gnt_i = 1'b0;
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL flush_req_abort gnt=%0b: got %h exp 0", with_gnt, obs());
    end
    bus.csr_gnt_i = 1'b1;
    drive_resp(t);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.csr_gnt_i    = 1'b0;
      bus.csr_rvalid_i = 1'b0;
      n_cmp++;
      if (obs() !== '0) begin
        n_fail++; $display("FAIL flush_req_quiet%0d: got %h exp 0", i, obs());
      end
    end
    $display("txn flush_in_req gnt_same_cycle=%0b", with_gnt);
  endtask

  task automatic test_flush_in_wait();
    txn_t t;
    t = mk(2'd3, 12'h300, 64'h8, 64'h8000_0300, 0, 2, 64'h1888, 0, 0, 1);
    arm(t);
    do_txn(t, 0, t, "flush_in_wait");
  endtask

  task automatic test_stall();
    txn_t t;
    t = mk(2'd0, 12'hf14, 64'h0, 64'h8000_0400, 0, 0, 64'h3, 0, 0, 0);
    arm(t);
    bus.halt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== '0) begin
        n_fail++; $display("FAIL halt_block%0d: got %h exp 0", i, obs());
      end
    end
    bus.halt_i  = 1'b0;
    bus.flush_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL flush_block: got %h exp 0", obs());
    end
    bus.flush_i = 1'b0;
    do_txn(t, 0, t, "after_stall");
  endtask

  task automatic test_reset_mid();
    txn_t t;
    t = mk(2'd1, 12'h305, 64'h1234, 64'h8000_0500, 0, 3, 64'h77, 0, 1, 0);
    arm(t);
    @(negedge clk);
    bus.commit_valid_i = 1'b0;
    bus.csr_gnt_i = 1'b1;
    @(negedge clk);
    bus.csr_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h exp 0", obs());
    end
    n_cmp++;
    if (fields() !== '0) begin
      n_fail++; $display("FAIL reset_mid_fields: got %h exp 0", fields());
    end
    drive_resp(t);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.csr_rvalid_i = 1'b0;
      n_cmp++;
      if (obs() !== '0) begin
        n_fail++; $display("FAIL reset_mid_quiet%0d: got %h exp 0", i, obs());
      end
    end
    $display("txn reset_mid_wait");
  endtask

  task automatic test_back_to_back();
    txn_t a;
    txn_t b;
    txn_t c;
    a = mk(2'd0, 12'h001, 64'h0, 64'h8000_1000, 0, 0, 64'h11, 0, 0, 0);
    b = mk(2'd1, 12'h180, 64'h99, 64'h8000_1004, 0, 0, 64'h22, 0, 1, 0);
    c = mk(2'd2, 12'h002, 64'h1, 64'h8000_1008, 0, 0, 64'h33, 0, 0, 0);
    arm(a);
    do_txn(a, 1, b, "b2b_a");
    do_txn(b, 1, c, "b2b_b");
    do_txn(c, 0, c, "b2b_c");
  endtask

  task automatic test_random();
    txn_t cur;
    txn_t nxt;
    bit   chain;
    cur = rand_txn();
    arm(cur);
    for (int i = 0; i < 40; i++) begin
      nxt   = rand_txn();
      chain = (i < 39) && ($urandom_range(0, 1) == 1);
      do_txn(cur, chain, nxt, $sformatf("rand%0d", i));
      if (!chain && i < 39) arm(nxt);
      cur = nxt;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.flush_i           = 1'b0;
    bus.halt_i            = 1'b0;
    bus.commit_valid_i    = 1'b0;
    bus.commit_cmd_i      = CSR_READ;
    bus.commit_pc_i       = '0;
    bus.buf_addr_i        = '0;
    bus.buf_wdata_i       = '0;
    bus.csr_gnt_i         = 1'b0;
    bus.csr_rvalid_i      = 1'b0;
    bus.csr_rdata_i       = '0;
    bus.csr_ex_i          = 1'b0;
    bus.csr_side_effect_i = 1'b0;

    test_reset();
    test_read_success();
    test_exception();
    test_side_effect();
    test_flush_in_req(1'b0);
    test_flush_in_req(1'b1);
    test_flush_in_wait();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
